// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the RV front end.
package rv_pipe_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0060;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline boundary register: {pc, instr, valid} with load enable and flush.
// Payload is only captured for live instructions; bubbles and flushes clear valid alone.
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= XLEN'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight, and feeds the IF/ID register.
// Redirects during an open read drain that read before fetching from the new target.
module if_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_pc,
  output logic [XLEN-1:0] IF_instr,
  output logic            IF_valid
);
  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            req_q, req_d;

  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_inc;

  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign pc_inc    = pc_q + XLEN'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    buf_d     = buf_q;
    req_d     = req_q;
    out_valid = 1'b0;
    out_instr = imem_rdata;

    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          // First cycle out of reset: nothing in flight yet.
          req_d = 1'b1;
          if (redirect) pc_d = redir_tgt;
        end else if (redirect) begin
          if (imem_resp) begin
            pc_d = redir_tgt;
          end else begin
            target_d = redir_tgt;
            state_d  = DISCARD;
          end
        end else if (imem_resp) begin
          if (stall) begin
            buf_d   = imem_rdata;
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            out_valid = 1'b1;
            pc_d      = pc_inc;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          out_valid = 1'b1;
          out_instr = buf_q;
          pc_d      = pc_inc;
          req_d     = 1'b1;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) target_d = redir_tgt;
        if (imem_resp) begin
          pc_d    = redirect ? redir_tgt : target_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= '0;
      buf_q    <= XLEN'(NOP_INSTR);
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      buf_q    <= buf_d;
      req_q    <= req_d;
    end
  end

  // pc_q is left untouched in DISCARD, so it still names the read being drained.
  assign imem_read    = req_q;
  assign imem_address = pc_q;

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (!stall || redirect),
    .flush_i(redirect),
    .pc_i   (pc_q),
    .instr_i(out_instr),
    .valid_i(out_valid),
    .pc_o   (IF_pc),
    .instr_o(IF_instr),
    .valid_o(IF_valid)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bench-side memory, transaction-level reference model,
// per-cycle compare process and hand-computed literal checkpoints.
module tb_if_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc;
  logic [31:0] IF_instr;
  logic        IF_valid;

  int n_vec = 0;
  int n_err = 0;
  int mem_wait = 0;
  int mcnt = 0;

  // Reference model state, described in terms of the fetch contract.
  bit          m_up;
  bit          m_held;
  bit          m_drop;
  bit          m_if_valid;
  logic [31:0] m_pc, m_after, m_held_instr, m_if_pc, m_if_instr;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_read   (imem_read),
    .imem_address(imem_address),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .IF_pc       (IF_pc),
    .IF_instr    (IF_instr),
    .IF_valid    (IF_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a read is open whenever out of reset and no instruction is parked.
  initial begin : model
    bit          open_r, got_r, have_r;
    logic [31:0] tgt_r, hin_r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_up = 0; m_held = 0; m_drop = 0; m_after = '0; m_held_instr = '0;
        m_pc = 32'h60; m_if_pc = '0; m_if_instr = 32'h13; m_if_valid = 0;
      end else begin
        open_r = m_up && !m_held;
        got_r  = open_r && imem_resp;
        tgt_r  = {redirect_pc[31:2], 2'b00};
        if (redirect) begin
          m_if_valid = 0;
          m_held     = 0;
          if (open_r && !got_r) begin
            m_drop = 1; m_after = tgt_r;
          end else begin
            m_drop = 0; m_pc = tgt_r;
          end
        end else if (got_r && m_drop) begin
          m_drop = 0;
          m_pc   = m_after;
          if (!stall) m_if_valid = 0;
        end else begin
          have_r = got_r || m_held;
          hin_r  = got_r ? imem_rdata : m_held_instr;
          if (!have_r) begin
            if (!stall) m_if_valid = 0;
          end else if (stall) begin
            m_held = 1; m_held_instr = hin_r;
          end else begin
            m_if_pc = m_pc; m_if_instr = hin_r; m_if_valid = 1;
            m_pc = m_pc + 32'd4; m_held = 0;
          end
        end
        m_up = 1;
      end
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("imem_read", {31'd0, imem_read}, {31'd0, m_up && !m_held});
      if (m_up && !m_held) chk("imem_address", imem_address, m_pc);
      chk("IF_valid", {31'd0, IF_valid}, {31'd0, m_if_valid});
      chk("IF_pc", IF_pc, m_if_pc);
      chk("IF_instr", IF_instr, m_if_instr);
    end
  end

  // One cycle: drive control inputs and the memory reply at negedge, return just after posedge.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    stall = st; redirect = rd; redirect_pc = rpc;
    if (imem_read) begin
      if (mcnt >= mem_wait + 1) begin
        imem_resp = 1'b1; imem_rdata = mem_data(imem_address); mcnt = 0;
      end else begin
        imem_resp = 1'b0; mcnt++;
      end
    end else begin
      imem_resp = 1'b0; mcnt = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0);
  endtask

  task automatic reset_assert();
    @(negedge clk); #2;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
    #1;
  endtask

  task automatic reset_release();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mcnt = 0; mem_wait = 0;
    stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
    @(posedge clk); #1;
    chk("rel_read", {31'd0, imem_read}, 32'd1);
    chk("rel_addr", imem_address, 32'h60);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_IF_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_IF_instr", IF_instr, 32'h0000_0013);
    chk("rst_IF_pc", IF_pc, 32'h0);
    chk("rst_read", {31'd0, imem_read}, 32'd0);

    // 1: zero-wait streaming
    reset_release();
    idle(2);
    chk("t1_IF_pc0", IF_pc, 32'h60);
    chk("t1_IF_instr0", IF_instr, 32'hA5A5_0073);
    chk("t1_valid0", {31'd0, IF_valid}, 32'd1);
    chk("t1_addr1", imem_address, 32'h64);
    idle(1);
    chk("t1_bubble", {31'd0, IF_valid}, 32'd0);
    idle(1);
    chk("t1_IF_pc1", IF_pc, 32'h64);
    chk("t1_addr2", imem_address, 32'h68);
    idle(2);
    chk("t1_IF_pc2", IF_pc, 32'h68);

    // 2: stall on the response for 0x64
    reset_assert(); reset_release();
    idle(3);
    tick(1'b1, 1'b0, 32'h0);
    chk("t2_hold_read", {31'd0, imem_read}, 32'd0);
    chk("t2_hold_pc", IF_pc, 32'h60);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("t2_hold_read3", {31'd0, imem_read}, 32'd0);
    tick(1'b0, 1'b0, 32'h0);
    chk("t2_rel_pc", IF_pc, 32'h64);
    chk("t2_rel_valid", {31'd0, IF_valid}, 32'd1);
    chk("t2_rel_addr", imem_address, 32'h68);
    idle(2);
    chk("t2_IF_pc", IF_pc, 32'h68);

    // 3: redirect while a slow read is open
    reset_assert(); reset_release();
    idle(2);
    mem_wait = 4;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h200);
    chk("t3_drain_addr", imem_address, 32'h64);
    idle(3);
    chk("t3_drain_addr2", imem_address, 32'h64);
    chk("t3_drain_read", {31'd0, imem_read}, 32'd1);
    idle(1);
    chk("t3_dropped", {31'd0, IF_valid}, 32'd0);
    chk("t3_new_addr", imem_address, 32'h200);
    mem_wait = 0;
    idle(2);
    chk("t3_IF_pc", IF_pc, 32'h200);
    chk("t3_IF_instr", IF_instr, 32'hA5A5_0213);

    // 4: redirect + stall in the response cycle
    reset_assert(); reset_release();
    idle(1);
    tick(1'b1, 1'b1, 32'h303);
    chk("t4_flush", {31'd0, IF_valid}, 32'd0);
    chk("t4_addr", imem_address, 32'h300);
    idle(2);
    chk("t4_IF_pc", IF_pc, 32'h300);
    chk("t4_IF_instr", IF_instr, 32'hA5A5_0313);

    // 5: PC wrap at the top of the address space
    reset_assert(); reset_release();
    tick(1'b0, 1'b1, 32'hFFFF_FFFD);
    idle(1);
    chk("t5_addr_top", imem_address, 32'hFFFF_FFFC);
    idle(2);
    chk("t5_IF_pc_top", IF_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_addr", imem_address, 32'h0);
    idle(2);
    chk("t5_IF_pc_zero", IF_pc, 32'h0);
    chk("t5_IF_instr_zero", IF_instr, 32'hA5A5_0013);

    // 6: reset mid-request with a stale response arriving during reset
    reset_assert(); reset_release();
    mem_wait = 4;
    idle(2);
    reset_assert();
    chk("t6_read", {31'd0, imem_read}, 32'd0);
    chk("t6_IF_pc", IF_pc, 32'h0);
    chk("t6_IF_instr", IF_instr, 32'h0000_0013);
    chk("t6_IF_valid", {31'd0, IF_valid}, 32'd0);
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_resp = 1'b0;
    reset_release();
    idle(1);
    chk("t6_no_stale", {31'd0, IF_valid}, 32'd0);
    idle(1);
    chk("t6_IF_pc_after", IF_pc, 32'h60);
    chk("t6_IF_instr_after", IF_instr, 32'hA5A5_0073);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
